// File: rtl/blk_f555b9_if.sv
// blk_f555b9_if: configuration-chain bus for the constant generator.
// Carries cfg_err only when CONST_GEN_PARITY_EN is defined.
interface blk_f555b9_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 1
);
    logic                    config_enable;
    logic                    ccff_head;
    logic                    ccff_tail;
    logic [NUM_CH*WIDTH-1:0] const_out;
    logic                    cfg_done;
`ifdef CONST_GEN_PARITY_EN
    logic                    cfg_err;
    modport master (output config_enable, ccff_head, input ccff_tail, const_out, cfg_done, cfg_err);
    modport slave  (input config_enable, ccff_head, output ccff_tail, const_out, cfg_done, cfg_err);
`else
    modport master (output config_enable, ccff_head, input ccff_tail, const_out, cfg_done);
    modport slave  (input config_enable, ccff_head, output ccff_tail, const_out, cfg_done);
`endif
endinterface

// File: rtl/blk_f555b9.sv
// blk_f555b9: multi-channel constant driver loaded serially, committed atomically.
// Optional CONST_GEN_PARITY_EN appends an even-parity bit to the chain and adds cfg_err.
module blk_f555b9 #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 1,
    parameter bit RST_ONE = 1'b1
) (
    input logic        prog_clk,
    input logic        pReset,
    blk_f555b9_if.slave bus
);
    localparam int N = NUM_CH * WIDTH;
`ifdef CONST_GEN_PARITY_EN
    localparam int L = N + 1;
`else
    localparam int L = N;
`endif
    localparam int CW = $clog2(L + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DONE} state_t;
    state_t        state_q;
    logic [L-1:0]  sreg_q;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  const_q;
    logic          done_q, par_ok;
    // A new load restarts the count from any state other than SHIFT.
    assign count_d = state_q == SHIFT ? count_q + 1'b1 : CW'(1);
`ifdef CONST_GEN_PARITY_EN
    logic err_q;
    assign par_ok = ~^sreg_q;
    assign bus.cfg_err = err_q;
`else
    assign par_ok = 1'b1;
`endif
    assign bus.ccff_tail = sreg_q[L-1];
    assign bus.const_out = const_q;
    assign bus.cfg_done  = done_q;
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            count_q <= '0;
            const_q <= {N{RST_ONE}};
            done_q  <= 1'b0;
`ifdef CONST_GEN_PARITY_EN
            err_q   <= 1'b0;
`endif
        end else if (state_q == COMMIT) begin
            state_q <= par_ok ? DONE : IDLE;
            done_q  <= par_ok;
            if (par_ok) const_q <= sreg_q[L-1 -: N];
`ifdef CONST_GEN_PARITY_EN
            err_q   <= !par_ok;
`endif
        end else if (bus.config_enable) begin
            sreg_q  <= (sreg_q << 1) | L'(bus.ccff_head);
            count_q <= count_d;
            state_q <= count_d == CW'(L) ? COMMIT : SHIFT;
            done_q  <= 1'b0;
`ifdef CONST_GEN_PARITY_EN
            err_q   <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_blk_f555b9.sv
// tb_blk_f555b9: directed loads against a queue-based model of the constant generator.
// Two instances cover both reset polarities of const_out.
module tb_blk_f555b9;
    localparam int N = 4;
`ifdef CONST_GEN_PARITY_EN
    localparam int L = N + 1;
`else
    localparam int L = N;
`endif
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, head = 1'b0;
    int checks = 0, fails = 0;
    always #5 clk = ~clk;
    blk_f555b9_if #(.NUM_CH(4), .WIDTH(1)) b1 ();
    blk_f555b9_if #(.NUM_CH(4), .WIDTH(1)) b0 ();
    assign b1.config_enable = en;
    assign b1.ccff_head     = head;
    assign b0.config_enable = en;
    assign b0.ccff_head     = head;
    blk_f555b9 #(.NUM_CH(4), .WIDTH(1), .RST_ONE(1'b1)) dut1 (.prog_clk(clk), .pReset(rst), .bus(b1.slave));
    blk_f555b9 #(.NUM_CH(4), .WIDTH(1), .RST_ONE(1'b0)) dut0 (.prog_clk(clk), .pReset(rst), .bus(b0.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bits of the current load in a queue, full history for the tail.
    bit         q_cur[$];
    bit         q_hist[$];
    logic       m_pend, m_done, m_err, m_ok;
    logic [3:0] m_c1, m_c0, m_d;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_cur.delete();
            q_hist.delete();
            m_pend = 0; m_done = 0; m_err = 0;
            m_c1 = 4'hF; m_c0 = 4'h0;
        end else if (m_pend) begin
            m_d = {q_cur[0], q_cur[1], q_cur[2], q_cur[3]};
            m_ok = 1;
            if (L != N) foreach (q_cur[i]) m_ok ^= q_cur[i];
            if (L == N) m_ok = 1;
            if (m_ok) begin m_c1 = m_d; m_c0 = m_d; end
            m_done = m_ok; m_err = !m_ok;
            q_cur.delete();
            m_pend = 0;
        end else if (en) begin
            q_cur.push_back(head);
            q_hist.push_back(head);
            m_done = 0; m_err = 0;
            if (q_cur.size() == L) m_pend = 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("const_out", 32'(b1.const_out), 32'(m_c1));
            chk("const_out_rst0", 32'(b0.const_out), 32'(m_c0));
            chk("cfg_done", 32'(b1.cfg_done), 32'(m_done));
            chk("ccff_tail", 32'(b1.ccff_tail), q_hist.size() >= L ? 32'(q_hist[q_hist.size()-L]) : 32'd0);
`ifdef CONST_GEN_PARITY_EN
            chk("cfg_err", 32'(b1.cfg_err), 32'(m_err));
`endif
        end
    end

    task automatic put(input logic e, input logic b);
        en = e; head = b;
        @(negedge clk);
    endtask
    task automatic shift_n(input logic [3:0] d, input int from, input int to);
        for (int i = from; i < to; i++) put(1'b1, d[3-i]);
    endtask
    task automatic shift_par(input logic [3:0] d);
`ifdef CONST_GEN_PARITY_EN
        put(1'b1, ^d);
`endif
    endtask
    task automatic do_reset();
        en = 0; rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_const1", 32'(b1.const_out), 32'hF);
        chk("rst_const0", 32'(b0.const_out), 32'h0);
        chk("rst_done", 32'(b1.cfg_done), 32'h0);
        chk("rst_tail", 32'(b1.ccff_tail), 32'h0);
        rst = 0;
        // full load
        shift_n(4'b1011, 0, 4);
        shift_par(4'b1011);
        chk("load_tail_first_bit", 32'(b1.ccff_tail), 32'h1);
        chk("load_before_commit", 32'(b1.const_out), 32'hF);
        put(1'b0, 1'b0);
        chk("load_commit", 32'(b1.const_out), 32'hB);
        chk("load_done", 32'(b1.cfg_done), 32'h1);
        chk("load_commit_rst0", 32'(b0.const_out), 32'hB);
        // reload
        put(1'b1, 1'b0);
        chk("reload_done_drop", 32'(b1.cfg_done), 32'h0);
        chk("reload_hold", 32'(b1.const_out), 32'hB);
        shift_n(4'b0100, 1, 4);
        shift_par(4'b0100);
        chk("reload_hold_end", 32'(b1.const_out), 32'hB);
        put(1'b0, 1'b0);
        chk("reload_commit", 32'(b1.const_out), 32'h4);
        chk("reload_done", 32'(b1.cfg_done), 32'h1);
        // paused load from reset
        do_reset();
        shift_n(4'b1011, 0, 2);
        repeat (5) begin
            put(1'b0, 1'b1);
            chk("pause_hold", 32'(b1.const_out), 32'hF);
        end
        shift_n(4'b1011, 2, 4);
        shift_par(4'b1011);
        put(1'b0, 1'b0);
        chk("pause_commit", 32'(b1.const_out), 32'hB);
        chk("pause_done", 32'(b1.cfg_done), 32'h1);
        // reset part-way through a load
        shift_n(4'b1111, 0, 3);
        en = 0;
        #2 rst = 1;
        #1 chk("midrst_const1", 32'(b1.const_out), 32'hF);
        chk("midrst_const0", 32'(b0.const_out), 32'h0);
        chk("midrst_done", 32'(b1.cfg_done), 32'h0);
        rst = 0;
        @(negedge clk);
        shift_n(4'b0110, 0, 4);
        shift_par(4'b0110);
        put(1'b0, 1'b0);
        chk("midrst_reload", 32'(b1.const_out), 32'h6);
        chk("midrst_reload_done", 32'(b1.cfg_done), 32'h1);
`ifdef CONST_GEN_PARITY_EN
        do_reset();
        shift_n(4'b1011, 0, 4);
        put(1'b1, 1'b1);
        put(1'b0, 1'b0);
        chk("par_ok_const", 32'(b1.const_out), 32'hB);
        chk("par_ok_err", 32'(b1.cfg_err), 32'h0);
        shift_n(4'b0100, 0, 4);
        put(1'b1, 1'b0);
        put(1'b0, 1'b0);
        chk("par_bad_const", 32'(b1.const_out), 32'hB);
        chk("par_bad_err", 32'(b1.cfg_err), 32'h1);
        chk("par_bad_done", 32'(b1.cfg_done), 32'h0);
        put(1'b1, 1'b1);
        chk("par_err_clear", 32'(b1.cfg_err), 32'h0);
`endif
        repeat (3) put(1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
